// File: rtl/mem_lsu_pkg.sv
// Shared encodings for the MEM-stage load/store unit: memory op codes and FSM states.
package mem_lsu_pkg;

  typedef enum logic [3:0] {
    MEM_NONE = 4'd0,
    MEM_LB   = 4'd1,
    MEM_LH   = 4'd2,
    MEM_LW   = 4'd3,
    MEM_LBU  = 4'd4,
    MEM_LHU  = 4'd5,
    MEM_SB   = 4'd6,
    MEM_SH   = 4'd7,
    MEM_SW   = 4'd8
  } mem_op_e;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_REQ  = 2'd1,
    LSU_RSP  = 2'd2
  } lsu_state_e;

endpackage

// File: rtl/mem_lsu_align.sv
// Combinational lane logic: byte enables, store-data replication, load extraction
// and alignment checking for one memory op.
module mem_lsu_align
  import mem_lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [3:0]      mem_op,
  input  logic [1:0]      addr_lo,
  input  logic [XLEN-1:0] st_data,
  input  logic [XLEN-1:0] rdata,
  output logic [3:0]      be,
  output logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] ld_data,
  output logic            misalign,
  output logic            is_load,
  output logic            is_mem
);

  mem_op_e    op;
  logic [7:0] lane_bytes [4];
  logic [7:0] byte_sel;
  logic [15:0] half_sel;

  assign op = mem_op_e'(mem_op);

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign lane_bytes[gi] = rdata[8*gi +: 8];
  end

  assign byte_sel = lane_bytes[addr_lo];
  assign half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    be       = 4'b0000;
    wdata    = '0;
    ld_data  = '0;
    misalign = 1'b0;
    is_load  = 1'b0;
    is_mem   = 1'b1;
    case (op)
      MEM_LB, MEM_LBU: begin
        is_load = 1'b1;
        be      = 4'b0001 << addr_lo;
        ld_data = (op == MEM_LB) ? {{(XLEN-8){byte_sel[7]}}, byte_sel}
                                 : {{(XLEN-8){1'b0}}, byte_sel};
      end
      MEM_LH, MEM_LHU: begin
        is_load  = 1'b1;
        misalign = addr_lo[0];
        be       = addr_lo[1] ? 4'b1100 : 4'b0011;
        ld_data  = (op == MEM_LH) ? {{(XLEN-16){half_sel[15]}}, half_sel}
                                  : {{(XLEN-16){1'b0}}, half_sel};
      end
      MEM_LW: begin
        is_load  = 1'b1;
        misalign = (addr_lo != 2'b00);
        be       = 4'b1111;
        ld_data  = rdata;
      end
      MEM_SB: begin
        be    = 4'b0001 << addr_lo;
        wdata = {4{st_data[7:0]}};
      end
      MEM_SH: begin
        misalign = addr_lo[0];
        be       = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata    = {2{st_data[15:0]}};
      end
      MEM_SW: begin
        misalign = (addr_lo != 2'b00);
        be       = 4'b1111;
        wdata    = st_data;
      end
      default: is_mem = 1'b0;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: passes ALU results through, or runs one req/gnt/rvalid
// data-bus transaction per load/store while stalling the upstream pipeline.
module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rd_we_i,
  input  logic [XLEN-1:0]       rd_data_i,
  input  logic [REG_ADDR_W-1:0] rd_addr_i,
  input  logic [3:0]            mem_op_i,
  input  logic [XLEN-1:0]       st_data_i,
  output logic                  dbus_req_o,
  output logic                  dbus_we_o,
  output logic [XLEN-1:0]       dbus_addr_o,
  output logic [3:0]            dbus_be_o,
  output logic [XLEN-1:0]       dbus_wdata_o,
  input  logic                  dbus_gnt_i,
  input  logic                  dbus_rvalid_i,
  input  logic [XLEN-1:0]       dbus_rdata_i,
  output logic                  rd_we_o,
  output logic [XLEN-1:0]       rd_data_o,
  output logic [REG_ADDR_W-1:0] rd_addr_o,
  output logic                  stall_o,
  output logic                  misalign_o
);

  lsu_state_e      state_reg, state_next;
  logic [3:0]      be;
  logic [XLEN-1:0] wdata;
  logic [XLEN-1:0] ld_data;
  logic            misalign;
  logic            is_load;
  logic            is_mem;

  mem_lsu_align #(.XLEN(XLEN)) u_align (
    .mem_op   (mem_op_i),
    .addr_lo  (rd_data_i[1:0]),
    .st_data  (st_data_i),
    .rdata    (dbus_rdata_i),
    .be       (be),
    .wdata    (wdata),
    .ld_data  (ld_data),
    .misalign (misalign),
    .is_load  (is_load),
    .is_mem   (is_mem)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= LSU_IDLE;
    else        state_reg <= state_next;
  end

  // Outputs are forced low while reset is asserted, including the pass-through path.
  always_comb begin
    state_next   = state_reg;
    dbus_req_o   = 1'b0;
    dbus_we_o    = 1'b0;
    dbus_addr_o  = '0;
    dbus_be_o    = 4'b0000;
    dbus_wdata_o = '0;
    rd_we_o      = 1'b0;
    rd_data_o    = '0;
    rd_addr_o    = '0;
    stall_o      = 1'b0;
    misalign_o   = 1'b0;
    if (rst_n) begin
      rd_we_o   = rd_we_i;
      rd_data_o = rd_data_i;
      rd_addr_o = rd_addr_i;
      case (state_reg)
        LSU_IDLE: begin
          if (is_mem && misalign) begin
            misalign_o = 1'b1;
            rd_we_o    = 1'b0;
          end else if (is_mem) begin
            dbus_req_o = 1'b1;
            stall_o    = 1'b1;
            rd_we_o    = 1'b0;
            state_next = dbus_gnt_i ? LSU_RSP : LSU_REQ;
          end
        end
        LSU_REQ: begin
          dbus_req_o = 1'b1;
          stall_o    = 1'b1;
          rd_we_o    = 1'b0;
          if (dbus_gnt_i) state_next = LSU_RSP;
        end
        LSU_RSP: begin
          stall_o = !dbus_rvalid_i;
          rd_we_o = is_load;
          if (is_load) rd_data_o = ld_data;
          if (dbus_rvalid_i) state_next = LSU_IDLE;
        end
        default: state_next = LSU_IDLE;
      endcase
      // Upstream holds its inputs while stalled, so the request fields stay constant.
      if (dbus_req_o) begin
        dbus_we_o    = !is_load;
        dbus_addr_o  = {rd_data_i[XLEN-1:2], 2'b00};
        dbus_be_o    = be;
        dbus_wdata_o = wdata;
      end
    end
  end

endmodule
